amba_axi_read: RTL and testbench

AXI3 read initiator for the AAC decoder: accepts a word-aligned read request (address and beat count) from the AAC core, issues one INCR burst on the AR channel, and collects the R-channel beats. Beats are buffered in a 2-entry FIFO and handed to the AAC core over a valid/ready stream, with a last marker and a per-burst error flag. It is the read-side companion of the decoder's AXI write initiator and sits between the AAC core and the AMBA interconnect.

---
 rtl/amba_axi_pkg.sv | 27 ++
 rtl/amba_axi_rfifo.sv | 47 ++++
 rtl/amba_axi_read.sv | 138 +++++++++++++
 tb/tb_amba_axi_read.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amba_axi_pkg.sv
// Shared AXI3 initiator definitions: FSM states, fixed AR/AW
// attribute encodings and the read-beat buffer entry layout.
package amba_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN
  } axi_state_e;

  localparam logic [2:0] SIZE_WORD     = 3'b010;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] LOCK_NORMAL   = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0001;
  localparam logic [2:0] PROT_DEFAULT  = 3'b010;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } rbeat_t;

  localparam int RBEAT_W = $bits(rbeat_t);

endpackage

// File: rtl/amba_axi_rfifo.sv
// 2-entry synchronous FIFO for read beats {data, last, err}.
// Ports: push/wdata in, pop in, rdata = head entry, count = fill level.
module amba_axi_rfifo
  import amba_axi_pkg::*;
#(
  parameter int W = RBEAT_W
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wptr;
  logic         rptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & (count != 2'd2);
  assign do_pop  = pop & (count != 2'd0);
  assign rdata   = rptr ? mem1 : mem0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem0  <= '0;
      mem1  <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        if (wptr) mem1 <= wdata;
        else      mem0 <= wdata;
        wptr <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      count <= count + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/amba_axi_read.sv
// AXI3 read initiator: one INCR burst per AAC request, beats streamed
// to the AAC core through a 2-entry FIFO with last/error marking.
// Ports: aac* request/stream side, ar*/r* AXI3 read channels.
module amba_axi_read
  import amba_axi_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] aacaddr,
  input  logic [3:0]  aaclen,
  input  logic        aacaddrvalid,
  output logic        aacaddrready,
  output logic [31:0] aacdata,
  output logic        aacdatavalid,
  output logic        aacdatalast,
  output logic        aacerror,
  input  logic        aacdataready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [3:0] ARID = 4'b0010;

  axi_state_e state;
  axi_state_e state_nxt;

  logic [4:0]         cnt;
  logic               err_flag;
  logic [1:0]         fcount;
  logic               push;
  logic               pop;
  logic               beat_bad;
  logic               overrun;
  rbeat_t             wbeat;
  rbeat_t             head;
  logic [RBEAT_W-1:0] head_raw;

  assign arid    = ARID;
  assign arsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign arlock  = LOCK_NORMAL;
  assign arcache = CACHE_DEFAULT;
  assign arprot  = PROT_DEFAULT;

  assign aacaddrready = (state == ST_IDLE);
  // Only registered terms here: the AAC ready must not reach rready.
  assign rready = (state == ST_DATA) & (fcount != 2'd2);

  assign push = rvalid & rready;
  assign pop  = aacdatavalid & aacdataready;

  assign beat_bad = (rresp != RESP_OKAY) | (rid != ARID);
  // Beat index arlen should carry rlast; if not, the burst ran long.
  assign overrun  = (cnt == {1'b0, arlen}) & ~rlast;

  always_comb begin
    wbeat      = '0;
    wbeat.data = rdata;
    wbeat.last = rlast;
    wbeat.err  = err_flag | beat_bad
               | (cnt != {1'b0, arlen});
  end

  amba_axi_rfifo #(.W(RBEAT_W)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .wdata   (wbeat),
    .pop     (pop),
    .rdata   (head_raw),
    .count   (fcount)
  );

  assign head         = rbeat_t'(head_raw);
  assign aacdatavalid = (fcount != 2'd0);
  assign aacdata      = head.data;
  assign aacdatalast  = aacdatavalid & head.last;
  assign aacerror     = aacdatalast & head.err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (aacaddrvalid) state_nxt = ST_ADDR;
      ST_ADDR:  if (arready) state_nxt = ST_DATA;
      ST_DATA:  if (push & rlast) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if ((fcount == 2'd0) ||
            ((fcount == 2'd1) && pop))
          state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      araddr   <= '0;
      arlen    <= '0;
      arvalid  <= 1'b0;
      cnt      <= '0;
      err_flag <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && aacaddrvalid) begin
        araddr   <= aacaddr & 32'hFFFF_FFFC;
        arlen    <= aaclen;
        arvalid  <= 1'b1;
        cnt      <= '0;
        err_flag <= 1'b0;
      end
      if ((state == ST_ADDR) && arready)
        arvalid <= 1'b0;
      if (push) begin
        cnt      <= cnt + 5'd1;
        err_flag <= err_flag | beat_bad | overrun;
      end
    end
  end

endmodule

// File: tb/tb_amba_axi_read.sv
// Randomised self-checking bench for amba_axi_read with an
// expected-beat queue and per-cycle handshake-level checks.
module tb_amba_axi_read;

  logic        aclk;
  logic        aresetn;
  logic [31:0] aacaddr;
  logic [3:0]  aaclen;
  logic        aacaddrvalid;
  logic        aacaddrready;
  logic [31:0] aacdata;
  logic        aacdatavalid;
  logic        aacdatalast;
  logic        aacerror;
  logic        aacdataready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  amba_axi_read dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .aacaddr      (aacaddr),
    .aaclen       (aaclen),
    .aacaddrvalid (aacaddrvalid),
    .aacaddrready (aacaddrready),
    .aacdata      (aacdata),
    .aacdatavalid (aacdatavalid),
    .aacdatalast  (aacdatalast),
    .aacerror     (aacerror),
    .aacdataready (aacdataready),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .arlock       (arlock),
    .arcache      (arcache),
    .arprot       (arprot),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        e;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          pop_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          buf_n = 0;
  int          peak_buf = 0;
  int          pops = 0;
  int          rdy_mode = 0;
  bit          busy = 0;
  bit          ar_pend = 0;
  bit          in_data = 0;
  bit          mon_en = 0;
  logic        last_err;
  logic [31:0] last_data;
  logic [31:0] exp_addr;
  logic [3:0]  exp_len;
  logic [31:0] seen_araddr;
  logic [3:0]  seen_arlen;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=1 required=0", nm);
  endtask

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc++;

  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0:       aacdataready = 1'b1;
      1:       aacdataready = 1'($urandom_range(0, 1));
      default: aacdataready = 1'b0;
    endcase
  end

  // Per-cycle monitor; all signals sampled mid-cycle.
  always @(negedge aclk) begin
    if (aresetn && mon_en) begin
      chk("aacaddrready", 32'(aacaddrready), 32'(!busy));
      chk("arvalid", 32'(arvalid), 32'(ar_pend));
      if (arvalid) begin
        chk("araddr", araddr, exp_addr);
        chk("arlen", 32'(arlen), 32'(exp_len));
        seen_araddr = araddr;
        seen_arlen  = arlen;
      end
      chk("aacdatavalid", 32'(aacdatavalid),
          32'(buf_n > 0));
      if (buf_n >= 2)
        chk("rready_full", 32'(rready), 32'd0);
      else
        chk("rready", 32'(rready), 32'(in_data));
      if (!(aacdatavalid && aacdatalast))
        chk("aacerror_mask", 32'(aacerror), 32'd0);
      if (aacdatavalid && aacdataready) begin
        if (expq.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("aacdata", aacdata, mon_e.d);
          chk("aacdatalast", 32'(aacdatalast),
              32'(mon_e.l));
          if (mon_e.l) begin
            chk("aacerror", 32'(aacerror), 32'(mon_e.e));
            busy = 1'b0;
          end
        end
        last_data = aacdata;
        if (aacdatalast) last_err = aacerror;
        pop_cyc.push_back(cyc);
        pops++;
        buf_n--;
      end
      if (rvalid && rready) begin
        buf_n++;
        if (rlast) in_data = 1'b0;
      end
      if (buf_n > peak_buf) peak_buf = buf_n;
      if (arvalid && arready) begin
        ar_pend = 1'b0;
        in_data = 1'b1;
      end
      if (aacaddrvalid && aacaddrready) begin
        busy    = 1'b1;
        ar_pend = 1'b1;
      end
    end
  end

  // One request + AR handshake + n R beats + wait for drain.
  // Expected last-beat error: any bad beat or n != len+1.
  task automatic do_burst(input logic [31:0] addr,
                          input logic [3:0]  len,
                          input int          n,
                          input int          bad_resp,
                          input int          bad_id,
                          input int          maxgap,
                          input int          ard,
                          input logic [31:0] d0);
    logic [31:0] bd[32];
    logic [1:0]  br[32];
    logic [3:0]  bi[32];
    logic        anyerr;
    exp_t        e;
    int          c;
    int          to;
    anyerr = (n != int'(len) + 1);
    for (int i = 0; i < n; i++) begin
      bd[i] = (i == 0) ? d0 : $urandom;
      br[i] = (i == bad_resp) ?
              2'($urandom_range(1, 3)) : 2'b00;
      bi[i] = (i == bad_id) ? 4'h5 : 4'h2;
      if (br[i] != 2'b00 || bi[i] != 4'h2) anyerr = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      e.d = bd[i];
      e.l = (i == n - 1);
      e.e = e.l ? anyerr : 1'b0;
      expq.push_back(e);
    end
    exp_addr = {addr[31:2], 2'b00};
    exp_len  = len;
    @(posedge aclk); #1;
    aacaddrvalid = 1'b1;
    aacaddr      = addr;
    aaclen       = len;
    arready      = (ard == 0);
    @(posedge aclk); #1;
    aacaddrvalid = 1'b0;
    aacaddr      = $urandom;
    aaclen       = 4'($urandom);
    c  = 0;
    to = 0;
    forever begin
      @(negedge aclk);
      if (arvalid && arready) break;
      if (++to > 50) begin
        timeout("ar_handshake");
        break;
      end
      @(posedge aclk); #1;
      c++;
      arready = (c >= ard);
    end
    @(posedge aclk); #1;
    arready = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (maxgap > 0)
        repeat ($urandom_range(0, maxgap)) begin
          @(posedge aclk); #1;
        end
      rvalid = 1'b1;
      rdata  = bd[i];
      rresp  = br[i];
      rid    = bi[i];
      rlast  = (i == n - 1);
      to = 0;
      forever begin
        @(negedge aclk);
        if (rready) break;
        if (++to > 200) begin
          timeout("r_handshake");
          break;
        end
        @(posedge aclk); #1;
      end
      @(posedge aclk); #1;
      rvalid = 1'b0;
      rlast  = 1'b0;
      rdata  = $urandom;
    end
    to = 0;
    while (busy && to < 1000) begin
      @(posedge aclk);
      to++;
    end
    if (busy) timeout("drain");
    @(posedge aclk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_aacaddrready"}, 32'(aacaddrready), 32'd1);
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(rready), 32'd0);
    chk({tag, "_aacdatavalid"}, 32'(aacdatavalid), 32'd0);
    chk({tag, "_aacdatalast"}, 32'(aacdatalast), 32'd0);
    chk({tag, "_aacerror"}, 32'(aacerror), 32'd0);
    chk({tag, "_aacdata"}, aacdata, 32'd0);
    chk({tag, "_araddr"}, araddr, 32'd0);
    chk({tag, "_arlen"}, 32'(arlen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int p0;
    int len;
    int n;
    int md;
    aresetn      = 1'b0;
    aacaddr      = '0;
    aaclen       = '0;
    aacaddrvalid = 1'b0;
    aacdataready = 1'b1;
    arready      = 1'b0;
    rid          = 4'h2;
    rdata        = '0;
    rresp        = 2'b00;
    rlast        = 1'b0;
    rvalid       = 1'b0;
    #2;
    chk_reset_outputs("rst0");
    chk("arid", 32'(arid), 32'h2);
    chk("arsize", 32'(arsize), 32'h2);
    chk("arburst", 32'(arburst), 32'h1);
    chk("arlock", 32'(arlock), 32'h0);
    chk("arcache", 32'(arcache), 32'h1);
    chk("arprot", 32'(arprot), 32'h2);
    repeat (3) @(posedge aclk);
    #3 aresetn = 1'b1;
    mon_en = 1'b1;

    // Single beat, unaligned address.
    rdy_mode = 0;
    do_burst(32'h0000_1003, 4'd0, 1, -1, -1, 0, 0,
             32'hCAFE_BABE);
    chk("single_araddr", seen_araddr, 32'h0000_1000);
    chk("single_arlen", 32'(seen_arlen), 32'd0);
    chk("single_data", last_data, 32'hCAFE_BABE);
    chk("single_err", 32'(last_err), 32'd0);
    chk("single_idle", 32'(aacaddrready), 32'd1);

    // 16 beats, full throughput.
    pop_cyc.delete();
    do_burst(32'h0000_2000, 4'd15, 16, -1, -1, 0, 0,
             $urandom);
    chk("b16_count", 32'(pop_cyc.size()), 32'd16);
    if (pop_cyc.size() == 16)
      chk("b16_span", 32'(pop_cyc[15] - pop_cyc[0]), 32'd15);

    // Backpressure: consumer stalls, FIFO fills to 2.
    peak_buf = 0;
    rdy_mode = 2;
    fork
      begin
        repeat (9) @(posedge aclk);
        rdy_mode = 0;
      end
    join_none
    do_burst(32'h0000_3000, 4'd3, 4, -1, -1, 0, 0,
             $urandom);
    chk("bp_peak", 32'(peak_buf), 32'd2);

    // Error response on beat 1 of 3, then a clean burst.
    do_burst(32'h0000_4000, 4'd2, 3, 1, -1, 0, 0,
             $urandom);
    chk("resp_err", 32'(last_err), 32'd1);
    do_burst(32'h0000_4100, 4'd2, 3, -1, -1, 0, 0,
             $urandom);
    chk("clean_after_err", 32'(last_err), 32'd0);

    // Early rlast: 2 beats for a 4-beat request.
    p0 = pops;
    do_burst(32'h0000_5000, 4'd3, 2, -1, -1, 0, 0,
             $urandom);
    chk("short_count", 32'(pops - p0), 32'd2);
    chk("short_err", 32'(last_err), 32'd1);

    // Wrong rid on a single beat.
    do_burst(32'h0000_6000, 4'd0, 1, -1, 0, 0, 0,
             $urandom);
    chk("rid_err", 32'(last_err), 32'd1);

    // Over-long burst: one extra beat after arlen+1.
    p0 = pops;
    do_burst(32'h0000_6100, 4'd1, 3, -1, -1, 0, 1,
             $urandom);
    chk("long_count", 32'(pops - p0), 32'd3);
    chk("long_err", 32'(last_err), 32'd1);

    // Reset in DATA with one beat buffered.
    rdy_mode = 2;
    exp_addr = 32'h0000_7000;
    exp_len  = 4'd3;
    @(posedge aclk); #1;
    aacaddrvalid = 1'b1;
    aacaddr      = 32'h0000_7000;
    aaclen       = 4'd3;
    arready      = 1'b1;
    @(posedge aclk); #1;
    aacaddrvalid = 1'b0;
    @(posedge aclk); #1;
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'h1234_5678;
    rlast   = 1'b0;
    rresp   = 2'b00;
    rid     = 4'h2;
    @(posedge aclk); #1;
    rvalid = 1'b0;
    @(negedge aclk);
    chk("rst_pre_valid", 32'(aacdatavalid), 32'd1);
    chk("rst_pre_rready", 32'(rready), 32'd1);
    #2;
    mon_en  = 1'b0;
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    expq.delete();
    buf_n   = 0;
    busy    = 1'b0;
    ar_pend = 1'b0;
    in_data = 1'b0;
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    mon_en = 1'b1;
    rdy_mode = 0;
    do_burst(32'h0000_8000, 4'd2, 3, -1, -1, 1, 1,
             32'h0BAD_F00D);
    chk("post_rst_err", 32'(last_err), 32'd0);

    // Random bursts with gaps, stalls and faults.
    rdy_mode = 1;
    for (int k = 0; k < 25; k++) begin
      len = $urandom_range(0, 15);
      md  = $urandom_range(0, 4);
      if (md == 3)      n = $urandom_range(1, len + 1);
      else if (md == 4) n = len + 2;
      else              n = len + 1;
      do_burst($urandom, 4'(len), n,
               ($urandom_range(0, 3) == 0) ?
                 $urandom_range(0, n - 1) : -1,
               ($urandom_range(0, 5) == 0) ?
                 $urandom_range(0, n - 1) : -1,
               2, $urandom_range(0, 2), $urandom);
    end
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
